adc_burst_capture: RTL and testbench
====================================

Name: adc_burst_capture

Overview:
- AXI-Stream slave at the far end of the ADC trigger-burst stream.
- Consumes 64-bit beats packed as {timestamp[48:0], sample[14:0]} and unpacks them.
- Stores one burst's samples in an internal BRAM, checks timestamp continuity, and exposes a random-access readout port plus status for the PS-side register bank.
- The producer ignores tready. Loss is therefore detected and flagged, never back-pressured.

Parameters:
- ADC_DATA_WIDTH, 14, ADC sample width. Stream sample field is ADC_DATA_WIDTH+1 bits, signed.
- TS_WIDTH, 49, timestamp field width. Equals 64-(ADC_DATA_WIDTH+1).
- DEPTH_LOG2, 10, buffer holds 2^DEPTH_LOG2 samples (1024 ≥ 1002-sample producer burst).

Ports:
- aclk  in  1  system clock
- areset  in  1  synchronous reset, active-high
- s_axis_tvalid  in  1  beat valid
- s_axis_tdata  in  64  {ts[63:15], sample[14:0]}
- s_axis_tready  out  1  high in ARMED and CAPTURE; informational only
- arm  in  1  single-cycle pulse that starts a new capture
- rd_addr  in  DEPTH_LOG2  readout sample index
- rd_data  out  16  signed sample at rd_addr, sign-extended
- busy  out  1  state is ARMED or CAPTURE
- done  out  1  state is DONE
- burst_len  out  DEPTH_LOG2+1  samples stored in the current/last burst
- start_ts  out  TS_WIDTH  timestamp of the first stored beat
- gap_error  out  1  sticky: timestamp discontinuity inside the burst
- overflow  out  1  sticky: beats arrived while the buffer was full
- dropped  out  16  saturating count of valid beats outside ARMED/CAPTURE

Behaviour:
- Reset values: all outputs 0 and state IDLE. BRAM contents are not cleared.
- Any areset cycle returns to IDLE immediately, including mid-capture.
- Unpack:
  - sample = tdata[14:0], sign-extended to 16 bits.
  - ts = tdata[63:15].
- FSM states: IDLE, ARMED, CAPTURE, DONE.
  - IDLE/DONE + arm → ARMED. Clears burst_len, start_ts, gap_error and overflow. Does not clear dropped.
  - ARMED + tvalid → CAPTURE.
    - Writes the sample to addr 0 and sets start_ts = ts.
    - burst_len = 1; prev_ts is recorded.
  - CAPTURE + tvalid, buffer not full:
    - Writes the sample to addr burst_len, then burst_len += 1.
    - If ts != prev_ts+1 (mod 2^TS_WIDTH), sets gap_error. The sample is still stored.
    - prev_ts updates every beat.
  - CAPTURE + tvalid, burst_len == 2^DEPTH_LOG2: beat discarded, overflow set, state unchanged.
  - CAPTURE + !tvalid → DONE on the next edge. The burst ends at the first idle cycle, since the producer streams continuously.
  - arm while ARMED or CAPTURE is ignored.
- dropped increments on tvalid in IDLE or DONE, and saturates at 0xFFFF.
- Latency and timing:
  - A beat accepted at edge N is readable from edge N+1.
  - burst_len is updated at edge N.
  - done asserts at the edge after the first !tvalid cycle.
- Readout:
  - Synchronous read with 1-cycle latency: rd_data valid the cycle after rd_addr is presented.
  - Legal in any state. Reading during CAPTURE returns whatever the RAM holds, with no read/write collision guarantee on the same address.
  - rd_addr ≥ burst_len returns stale data; it is not an error.
- Timestamp wrap: continuity check is modulo 2^TS_WIDTH, so 0x1_FFFF_FFFF_FFFF → 0 is not a gap.
- Same-cycle events:
  - arm and tvalid together in IDLE: go to ARMED, and the beat counts as dropped.
  - The next beat is the first capture.

Decomposition:
- Shared package holds:
  - stream field constants: SAMPLE_LSB=0, SAMPLE_W=ADC_DATA_WIDTH+1, TS_LSB=SAMPLE_W, TS_W=64-SAMPLE_W;
  - the FSM state encoding (IDLE=0, ARMED=1, CAPTURE=2, DONE=3), reused by the register bank for status readback.
- One sub-module: capture_ram, a simple dual-port RAM (1 write port, 1 registered read port), 16 bits × 2^DEPTH_LOG2, BRAM-inferable.

Test Plan:
- Reset then arm, then 1002 contiguous beats, ts 100..1101, sample = ts[14:0], then tvalid low.
  - Expect done=1, burst_len=1002, start_ts=100, gap_error=0, overflow=0.
  - rd_addr=5 gives rd_data=105 the cycle after.
- Burst with a ts jump 200→202 at beat 100, sample field 15'h7FFF.
  - Expect gap_error=1 and burst_len equal to the beats sent.
  - rd_data=16'hFFFF (sign extension).
- Arm, then 1030 contiguous beats.
  - Expect burst_len=1024, overflow=1, done after tvalid drops.
  - rd_addr=1023 gives the 1024th sample.
- 7 valid beats while IDLE, then arm, then a 3-beat burst.
  - Expect dropped=7, burst_len=3.
  - Second arm clears gap_error/overflow but keeps dropped=7.
- areset high for 1 cycle at beat 500 of a burst.
  - Expect state IDLE, all status 0, following beats counted in dropped, done=0.
- Burst across timestamp wrap: ts 2^49-2, 2^49-1, 0, 1.
  - Expect gap_error=0, burst_len=4, start_ts=2^49-2.

Source files
------------

// File: rtl/adc_burst_capture_pkg.sv
// Shared constants for the ADC burst stream beat layout and the capture FSM encoding.
// The state encoding is also what the register bank reports as status.
package adc_burst_capture_pkg;

  localparam int BEAT_W     = 64;
  localparam int ADC_W      = 14;
  localparam int SAMPLE_LSB = 0;
  localparam int SAMPLE_W   = ADC_W + 1;
  localparam int TS_LSB     = SAMPLE_W;
  localparam int TS_W       = BEAT_W - TS_LSB;
  localparam int RD_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/adc_burst_capture_if.sv
// AXI-Stream link carrying packed {timestamp, sample} beats from the ADC trigger path.
interface adc_burst_capture_if;
  import adc_burst_capture_pkg::*;

  logic              tvalid;
  logic [BEAT_W-1:0] tdata;
  logic              tready;

  modport master (output tvalid, output tdata, input  tready);
  modport slave  (input  tvalid, input  tdata, output tready);
endinterface

// File: rtl/adc_burst_capture_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module capture_ram #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: the array has no reset so it maps onto block RAM; only the output register is cleared.
  always_ff @(posedge aclk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge aclk) begin
    if (areset) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_burst_capture.sv
// Captures one ADC trigger burst into a sample buffer, checks timestamp continuity,
// and exposes random-access readout plus status. The producer ignores tready.
module adc_burst_capture
  import adc_burst_capture_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = ADC_W,
  parameter int TS_WIDTH       = TS_W,
  parameter int DEPTH_LOG2     = 10
) (
  input  logic                  aclk,
  input  logic                  areset,
  adc_burst_capture_if.slave    s_axis,
  input  logic                  arm,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [RD_W-1:0]       rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [DEPTH_LOG2:0]   burst_len,
  output logic [TS_WIDTH-1:0]   start_ts,
  output logic                  gap_error,
  output logic                  overflow,
  output logic [15:0]           dropped
);

  localparam int SW    = ADC_DATA_WIDTH + 1;
  localparam int TS_LO = SAMPLE_LSB + SW;

  cap_state_t          state, state_nxt;
  logic [TS_WIDTH-1:0] prev_ts, beat_ts;
  logic [SW-1:0]       beat_smp;
  logic [RD_W-1:0]     beat_ext;
  logic                buf_full, wr_en, busy_nxt;

  assign beat_smp = s_axis.tdata[SAMPLE_LSB +: SW];
  assign beat_ts  = s_axis.tdata[TS_LO +: TS_WIDTH];
  assign beat_ext = {{(RD_W-SW){beat_smp[SW-1]}}, beat_smp};
  assign buf_full = burst_len[DEPTH_LOG2];
  // In ARMED burst_len is zero, so the write address is burst_len in both writing states.
  assign wr_en    = s_axis.tvalid &&
                    ((state == ST_ARMED) || (state == ST_CAPTURE && !buf_full));

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (arm)            state_nxt = ST_ARMED;
      ST_ARMED:         if (s_axis.tvalid)  state_nxt = ST_CAPTURE;
      ST_CAPTURE:       if (!s_axis.tvalid) state_nxt = ST_DONE;
      default:                              state_nxt = ST_IDLE;
    endcase
  end

  assign busy_nxt = (state_nxt == ST_ARMED) || (state_nxt == ST_CAPTURE);

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      s_axis.tready <= 1'b0;
      burst_len     <= '0;
      start_ts      <= '0;
      prev_ts       <= '0;
      gap_error     <= 1'b0;
      overflow      <= 1'b0;
      dropped       <= '0;
    end else begin
      state         <= state_nxt;
      busy          <= busy_nxt;
      s_axis.tready <= busy_nxt;
      done          <= (state_nxt == ST_DONE);
      case (state)
        ST_IDLE, ST_DONE: begin
          if (s_axis.tvalid && dropped != 16'hFFFF) dropped <= dropped + 16'd1;
          if (arm) begin
            burst_len <= '0;
            start_ts  <= '0;
            gap_error <= 1'b0;
            overflow  <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (s_axis.tvalid) begin
            start_ts  <= beat_ts;
            prev_ts   <= beat_ts;
            burst_len <= (DEPTH_LOG2+1)'(1);
          end
        end
        ST_CAPTURE: begin
          if (s_axis.tvalid) begin
            if (buf_full) begin
              overflow <= 1'b1;
            end else begin
              burst_len <= burst_len + 1'b1;
              prev_ts   <= beat_ts;
              // Width-cast keeps the successor modulo 2^TS_WIDTH so a wrap is not a gap.
              if (beat_ts != TS_WIDTH'(prev_ts + 1'b1)) gap_error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  capture_ram #(
    .DW (RD_W),
    .AW (DEPTH_LOG2)
  ) u_ram (
    .aclk   (aclk),
    .areset (areset),
    .we     (wr_en),
    .waddr  (burst_len[DEPTH_LOG2-1:0]),
    .wdata  (beat_ext),
    .raddr  (rd_addr),
    .rdata  (rd_data)
  );

endmodule

// File: tb/tb_adc_burst_capture.sv
// Directed bench for adc_burst_capture: burst capture, gaps, overflow, drops, reset, ts wrap.
module tb_adc_burst_capture;
  import adc_burst_capture_pkg::*;

  logic        aclk = 1'b0;
  logic        areset;
  logic        arm;
  logic [9:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy, done, gap_error, overflow;
  logic [10:0] burst_len;
  logic [48:0] start_ts;
  logic [15:0] dropped;
  int          checks   = 0;
  int          failures = 0;

  localparam logic [48:0] TS_MAX = {49{1'b1}};

  adc_burst_capture_if s_axis ();

  adc_burst_capture dut (
    .aclk      (aclk),
    .areset    (areset),
    .s_axis    (s_axis),
    .arm       (arm),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .burst_len (burst_len),
    .start_ts  (start_ts),
    .gap_error (gap_error),
    .overflow  (overflow),
    .dropped   (dropped)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [48:0] ts, input logic [14:0] smp);
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = {ts, smp};
    tick();
  endtask

  task automatic idle();
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    tick();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    idle();
    arm = 1'b0;
  endtask

  task automatic read(input logic [9:0] a);
    rd_addr = a;
    tick();
  endtask

  initial begin
    areset = 1'b1; arm = 1'b0; rd_addr = '0;
    s_axis.tvalid = 1'b0; s_axis.tdata = '0;
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_tready", 64'(s_axis.tready), 64'd0);
    check("rst_len", 64'(burst_len), 64'd0);
    check("rst_start_ts", 64'(start_ts), 64'd0);
    check("rst_flags", 64'({gap_error, overflow}), 64'd0);
    check("rst_dropped", 64'(dropped), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    areset = 1'b0;
    tick();

    // Nominal 1002-beat burst.
    do_arm();
    check("arm_busy", 64'(busy), 64'd1);
    check("arm_tready", 64'(s_axis.tready), 64'd1);
    for (int i = 0; i < 1002; i++) begin
      beat(49'(100 + i), 15'(100 + i));
      if (i == 0) check("first_len", 64'(burst_len), 64'd1);
    end
    check("nom_done_early", 64'(done), 64'd0);
    idle();
    check("nom_done", 64'(done), 64'd1);
    check("nom_busy", 64'(busy), 64'd0);
    check("nom_len", 64'(burst_len), 64'd1002);
    check("nom_start_ts", 64'(start_ts), 64'd100);
    check("nom_flags", 64'({gap_error, overflow}), 64'd0);
    read(10'd5);
    check("nom_rd5", 64'(rd_data), 64'd105);
    read(10'd1001);
    check("nom_rd1001", 64'(rd_data), 64'd1101);

    // Burst with a 200 -> 202 timestamp jump, negative full-scale samples.
    do_arm();
    check("rearm_len", 64'(burst_len), 64'd0);
    check("rearm_done", 64'(done), 64'd0);
    for (int i = 0; i < 150; i++) begin
      beat((i <= 100) ? 49'(100 + i) : 49'(101 + i), 15'h7FFF);
      if (i == 100) check("gap_before", 64'(gap_error), 64'd0);
      if (i == 101) check("gap_at_jump", 64'(gap_error), 64'd1);
    end
    idle();
    check("gap_sticky", 64'(gap_error), 64'd1);
    check("gap_len", 64'(burst_len), 64'd150);
    read(10'd101);
    check("gap_rd_sext", 64'(rd_data), 64'hFFFF);

    // Overflow: 1030 beats into a 1024-entry buffer.
    do_arm();
    check("ovf_gap_cleared", 64'(gap_error), 64'd0);
    for (int i = 0; i < 1030; i++) begin
      beat(49'(5000 + i), 15'(i));
      if (i == 1023) check("ovf_not_yet", 64'({overflow, burst_len}), 64'h400);
    end
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_len", 64'(burst_len), 64'd1024);
    check("ovf_still_busy", 64'(busy), 64'd1);
    idle();
    check("ovf_done", 64'(done), 64'd1);
    read(10'd1023);
    check("ovf_rd1023", 64'(rd_data), 64'd1023);
    read(10'd0);
    check("ovf_rd0", 64'(rd_data), 64'd0);

    // Drops in IDLE, then a gapped 3-beat burst, then arm coinciding with a beat.
    areset = 1'b1; tick(); areset = 1'b0;
    for (int i = 0; i < 7; i++) beat(49'(i), 15'(i));
    check("drop7", 64'(dropped), 64'd7);
    check("drop_idle_busy", 64'(busy), 64'd0);
    idle();
    do_arm();
    beat(49'd10, 15'h7FFD);
    beat(49'd12, 15'h0001);
    beat(49'd13, 15'h0002);
    idle();
    check("b3_len", 64'(burst_len), 64'd3);
    check("b3_gap", 64'(gap_error), 64'd1);
    check("b3_dropped", 64'(dropped), 64'd7);
    read(10'd0);
    check("b3_rd0", 64'(rd_data), 64'hFFFD);
    arm = 1'b1;
    beat(49'd40, 15'd40);
    arm = 1'b0;
    check("armv_dropped", 64'(dropped), 64'd8);
    check("armv_clear", 64'({gap_error, overflow, burst_len}), 64'd0);
    check("armv_busy", 64'(busy), 64'd1);
    beat(49'd50, 15'd50);
    beat(49'd51, 15'd51);
    idle();
    check("armv_start_ts", 64'(start_ts), 64'd50);
    check("armv_len", 64'(burst_len), 64'd2);
    check("armv_gap", 64'(gap_error), 64'd0);

    // Reset in the middle of a burst.
    do_arm();
    for (int i = 0; i < 500; i++) beat(49'(1000 + i), 15'(i));
    areset = 1'b1;
    beat(49'd1500, 15'd500);
    areset = 1'b0;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_len", 64'(burst_len), 64'd0);
    check("mrst_status", 64'({gap_error, overflow, start_ts}), 64'd0);
    check("mrst_dropped", 64'(dropped), 64'd0);
    for (int i = 501; i < 506; i++) beat(49'(1000 + i), 15'(i));
    idle();
    check("mrst_drop5", 64'(dropped), 64'd5);
    check("mrst_done_after", 64'({done, busy}), 64'd0);

    // Timestamp wrap is continuous.
    do_arm();
    beat(TS_MAX - 49'd1, 15'd1);
    beat(TS_MAX, 15'd2);
    beat(49'd0, 15'd3);
    beat(49'd1, 15'd4);
    idle();
    check("wrap_gap", 64'(gap_error), 64'd0);
    check("wrap_len", 64'(burst_len), 64'd4);
    check("wrap_start_ts", 64'(start_ts), 64'h1_FFFF_FFFF_FFFE);
    check("wrap_done", 64'(done), 64'd1);
    read(10'd3);
    check("wrap_rd3", 64'(rd_data), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
